hs_to_sync_rx: RTL and testbench



---
 rtl/hs_to_sync_rx.sv | 120 ++++++++++++
 tb/tb_hs_to_sync_rx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hs_to_sync_rx.sv
// Clocked receiver for a four-phase bundled-data channel: synchronises the
// request, captures the bundled word into a small FIFO and returns a flop-driven ack.
module hs_to_sync_rx #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    output logic                         ack_o,
    output logic                         valid_o,
    output logic [DATA_WIDTH-1:0]        data_o,
    input  logic                         ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        WAIT_REQ = 1'b0,
        WAIT_REL = 1'b1
    } state_t;

    state_t                  r_state;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    r_ack;
    logic                    r_valid;
    logic [CW-1:0]           r_count;
    logic [PW-1:0]           r_wptr;
    logic [PW-1:0]           r_rptr;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    w_req_s;
    logic                    w_pop;
    logic                    w_push_ok;
    logic                    w_push;
    logic [CW-1:0]           w_count_nxt;

    assign w_req_s = r_sync[SYNC_STAGES-1];
    assign ack_o   = r_ack;
    assign valid_o = r_valid;
    assign count_o = r_count;
    assign data_o  = r_mem[r_rptr];

    // Push/pop decisions; a pop in the same cycle frees a slot for a full FIFO.
    always_comb begin
        w_pop       = r_valid & ready_i;
        w_push_ok   = (r_count < CW'(DEPTH)) | w_pop;
        w_push      = (r_state == WAIT_REQ) & w_req_s & w_push_ok;
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Request synchroniser: the only sampler of req_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], req_i};
        end
    end

    // Four-phase handshake FSM with flop-driven acknowledge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= WAIT_REQ;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                WAIT_REQ: begin
                    if (w_push) begin
                        r_state <= WAIT_REL;
                        r_ack   <= 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (!w_req_s) begin
                        r_state <= WAIT_REQ;
                        r_ack   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= WAIT_REQ;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage, pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= data_i;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
        end
    end

endmodule

// File: tb/tb_hs_to_sync_rx.sv
// Directed bench for hs_to_sync_rx: a producer model drives four-phase handshakes
// and a queue scoreboard checks every word popped through valid/ready.
module tb_hs_to_sync_rx;

    logic        clk;
    logic        rst_ni;
    logic        req_i;
    logic [31:0] data_i;
    logic        ack_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic        ready_i;
    logic [1:0]  count_o;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic        streaming = 1'b0;

    hs_to_sync_rx dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .req_i   (req_i),
        .data_i  (data_i),
        .ack_o   (ack_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i),
        .count_o (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until ack_o reaches the given level.
    task automatic wait_ack(input logic v, input string tag);
        int n = 0;
        while (ack_o !== v && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, ack_o}, {31'd0, v});
    endtask

    task automatic do_hs(input logic [31:0] d);
        @(negedge clk);
        data_i = d;
        req_i  = 1'b1;
        exp_q.push_back(d);
        wait_ack(1'b1, "hs_ack_rise");
        @(negedge clk);
        req_i = 1'b0;
        wait_ack(1'b0, "hs_ack_fall");
    endtask

    // Scoreboard: a word is consumed at the next rising edge when valid & ready.
    always @(negedge clk) begin
        #2;
        if (rst_ni) begin
            if (streaming) chk("stream_count_le1", {31'd0, (count_o > 2'd1)}, 32'd0);
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) chk("unexpected_pop", {31'd0, valid_o}, 32'd0);
                else chk("pop_data", data_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_ni  = 1'b0;
        req_i   = 1'b0;
        data_i  = 32'd0;
        ready_i = 1'b0;
        #1;
        chk("rst_ack", {31'd0, ack_o}, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_count", {30'd0, count_o}, 32'd0);
        chk("rst_data", data_o, 32'd0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_ack", {31'd0, ack_o}, 32'd0);
        chk("post_rst_count", {30'd0, count_o}, 32'd0);

        // Single transfer with exact latency.
        @(negedge clk);
        data_i = 32'hA5A5_0001;
        req_i  = 1'b1;
        exp_q.push_back(32'hA5A5_0001);
        @(negedge clk);
        @(negedge clk);
        chk("single_ack_edge2", {31'd0, ack_o}, 32'd0);
        @(negedge clk);
        chk("single_ack_edge3", {31'd0, ack_o}, 32'd1);
        chk("single_valid", {31'd0, valid_o}, 32'd1);
        chk("single_data", data_o, 32'hA5A5_0001);
        chk("single_count", {30'd0, count_o}, 32'd1);
        req_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("release_ack_m1", {31'd0, ack_o}, 32'd1);
        @(negedge clk);
        chk("release_ack_m2", {31'd0, ack_o}, 32'd0);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        chk("drain_count", {30'd0, count_o}, 32'd0);

        // Fill and stall.
        do_hs(32'd1);
        do_hs(32'd2);
        chk("fill_count", {30'd0, count_o}, 32'd2);
        @(negedge clk);
        data_i = 32'd3;
        req_i  = 1'b1;
        exp_q.push_back(32'd3);
        repeat (8) @(negedge clk);
        chk("stall_ack", {31'd0, ack_o}, 32'd0);
        chk("stall_count", {30'd0, count_o}, 32'd2);
        chk("stall_head", data_o, 32'd1);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        chk("pushpop_count", {30'd0, count_o}, 32'd2);
        chk("pushpop_ack", {31'd0, ack_o}, 32'd1);
        chk("pushpop_head", data_o, 32'd2);
        req_i = 1'b0;
        wait_ack(1'b0, "stall_release");
        ready_i = 1'b1;
        repeat (3) @(negedge clk);
        ready_i = 1'b0;
        chk("stall_drained", {30'd0, count_o}, 32'd0);

        // Streaming with ready held high.
        ready_i   = 1'b1;
        streaming = 1'b1;
        for (int k = 0; k < 16; k++) do_hs(32'(k));
        repeat (3) @(negedge clk);
        streaming = 1'b0;
        chk("stream_empty", {30'd0, count_o}, 32'd0);

        // Idle pop: ready while empty must not move anything.
        repeat (4) @(negedge clk);
        chk("idle_count", {30'd0, count_o}, 32'd0);
        chk("idle_valid", {31'd0, valid_o}, 32'd0);
        ready_i = 1'b0;
        do_hs(32'h0000_0055);
        chk("idle_next_data", data_o, 32'h0000_0055);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;

        // Mid-handshake reset in WAIT_REL with one entry stored.
        @(negedge clk);
        data_i = 32'hDEAD_BEEF;
        req_i  = 1'b1;
        exp_q.push_back(32'hDEAD_BEEF);
        wait_ack(1'b1, "midrst_ack_rise");
        chk("midrst_count_pre", {30'd0, count_o}, 32'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("midrst_ack", {31'd0, ack_o}, 32'd0);
        chk("midrst_valid", {31'd0, valid_o}, 32'd0);
        chk("midrst_count", {30'd0, count_o}, 32'd0);
        chk("midrst_data", data_o, 32'd0);
        req_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_ack_after", {31'd0, ack_o}, 32'd0);
        do_hs(32'h0000_0007);
        chk("fresh_data", data_o, 32'h0000_0007);
        chk("fresh_count", {30'd0, count_o}, 32'd1);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        @(negedge clk);
        chk("final_count", {30'd0, count_o}, 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
